// File: rtl/dequant.sv
`default_nettype none
// ============================================================================
// Module   : dequant
// Purpose  : Inverse-quantisation stage of the video-decode coefficient
//            pipeline. Raster-ordered quantised coefficients arrive MULTIPLE
//            per beat (64 per block). Each lane is scaled by the per-position
//            weight matrix, the quantiser scale and, for the intra DC term,
//            the DC multiplier. The result is saturated to the signed
//            COEF_WIDTH range.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: DEQUANT_NONLINEAR_QSCALE_EN
//   Defined   : q_scale_type (src_t_user[8]) = 1 selects the nonlinear
//               quantiser-scale table.
//   Undefined : src_t_user[8] is ignored and qs = 2*quantiser_scale_code.
// ----------------------------------------------------------------------------
// Ports (src_* / dst_* are the flattened nasti_stream_channel members):
//   aclk, aresetn      clock, asynchronous active-low reset
//   src_t_*            slave stream, quantised coefficients
//                      t_user[4:0] quantiser_scale_code, [5] intra,
//                      [7:6] intra_dc_precision, [8] q_scale_type,
//                      [USER_WIDTH+8:9] pass-through
//   dst_t_*            master stream, dequantised coefficients
//                      t_user = pass-through bits; strb/keep all ones, id 0
//   wm_we/sel/addr/data weight-table write port (sel 0 non-intra, 1 intra)
// ============================================================================
module dequant #(
  parameter int COEF_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // source stream
  input  logic                    src_t_valid,
  output logic                    src_t_ready,
  input  logic [DATA_WIDTH-1:0]   src_t_data,
  input  logic [DATA_WIDTH/8-1:0] src_t_strb,
  input  logic [DATA_WIDTH/8-1:0] src_t_keep,
  input  logic                    src_t_last,
  input  logic [DEST_WIDTH-1:0]   src_t_dest,
  input  logic [USER_WIDTH+8:0]   src_t_user,
  // destination stream
  output logic                    dst_t_valid,
  input  logic                    dst_t_ready,
  output logic [DATA_WIDTH-1:0]   dst_t_data,
  output logic [DATA_WIDTH/8-1:0] dst_t_strb,
  output logic [DATA_WIDTH/8-1:0] dst_t_keep,
  output logic                    dst_t_last,
  output logic [0:0]              dst_t_id,
  output logic [DEST_WIDTH-1:0]   dst_t_dest,
  output logic [USER_WIDTH-1:0]   dst_t_user,
  // weight matrix write port
  input  logic                    wm_we,
  input  logic                    wm_sel,
  input  logic [5:0]              wm_addr,
  input  logic [7:0]              wm_data
);

  localparam int MULTIPLE = DATA_WIDTH / COEF_WIDTH;
  localparam int BEATS    = 64 / MULTIPLE;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Worst case (2*QF+1)*255*112 needs COEF_WIDTH+17 bits; keep headroom.
  localparam int PW       = COEF_WIDTH + 20;

  localparam logic signed [PW-1:0] C_SAT_MAX =
    {{(PW-COEF_WIDTH+1){1'b0}}, {(COEF_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] C_SAT_MIN = ~C_SAT_MAX;
  localparam logic [CNT_W-1:0]     C_CNT_LAST = CNT_W'(BEATS-1);

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic en;
  logic dst_valid_q;
  logic accept;

  assign en          = !dst_valid_q || dst_t_ready;
  assign src_t_ready = en;
  assign accept      = src_t_valid && en;

  // --------------------------------------------------------------------------
  // Weight tables, [0] non-intra, [1] intra
  // --------------------------------------------------------------------------
  logic [7:0] wtab_q [2][64];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int t = 0; t < 2; t++) begin
        for (int a = 0; a < 64; a++) begin
          wtab_q[t][a] <= 8'd16;
        end
      end
    end else if (wm_we) begin
      wtab_q[wm_sel][wm_addr] <= wm_data;
    end
  end

  // --------------------------------------------------------------------------
  // Coefficient beat counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      if (src_t_last || (cnt_q == C_CNT_LAST)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-beat control fields
  // --------------------------------------------------------------------------
  logic [4:0] w_code;
  logic       w_intra;
  logic [1:0] w_prec;
  logic [7:0] w_qs;

  assign w_code  = src_t_user[4:0];
  assign w_intra = src_t_user[5];
  assign w_prec  = src_t_user[7:6];

`ifdef DEQUANT_NONLINEAR_QSCALE_EN
  function automatic logic [7:0] nl_qscale(input logic [4:0] code);
    logic [7:0] v;
    case (code)
      5'd0:  v = 8'd0;    5'd1:  v = 8'd1;    5'd2:  v = 8'd2;    5'd3:  v = 8'd3;
      5'd4:  v = 8'd4;    5'd5:  v = 8'd5;    5'd6:  v = 8'd6;    5'd7:  v = 8'd7;
      5'd8:  v = 8'd8;    5'd9:  v = 8'd10;   5'd10: v = 8'd12;   5'd11: v = 8'd14;
      5'd12: v = 8'd16;   5'd13: v = 8'd18;   5'd14: v = 8'd20;   5'd15: v = 8'd22;
      5'd16: v = 8'd24;   5'd17: v = 8'd28;   5'd18: v = 8'd32;   5'd19: v = 8'd36;
      5'd20: v = 8'd40;   5'd21: v = 8'd44;   5'd22: v = 8'd48;   5'd23: v = 8'd52;
      5'd24: v = 8'd56;   5'd25: v = 8'd64;   5'd26: v = 8'd72;   5'd27: v = 8'd80;
      5'd28: v = 8'd88;   5'd29: v = 8'd96;   5'd30: v = 8'd104;  default: v = 8'd112;
    endcase
    return v;
  endfunction

  always_comb begin
    w_qs = {2'b00, w_code, 1'b0};
    if (src_t_user[8]) begin
      w_qs = nl_qscale(w_code);
    end
  end
`else
  logic w_unused_qtype;
  assign w_unused_qtype = src_t_user[8];
  assign w_qs = {2'b00, w_code, 1'b0};
`endif

  // --------------------------------------------------------------------------
  // Lane datapath
  // --------------------------------------------------------------------------
  logic signed [PW-1:0]         w_prod    [MULTIPLE];
  logic                         w_dc      [MULTIPLE];
  logic signed [PW-1:0]         s1_prod_q [MULTIPLE];
  logic                         s1_dc_q   [MULTIPLE];
  logic        [COEF_WIDTH-1:0] w_res     [MULTIPLE];

  for (genvar l = 0; l < MULTIPLE; l++) begin : g_lane
    logic signed [PW-1:0]         lw_qf, lw_m, lw_wx, lw_qsx, lw_prod, lw_div;
    logic        [5:0]            lw_k;
    logic        [7:0]            lw_w;
    logic                         lw_dc;
    logic        [COEF_WIDTH-1:0] lw_res;

    // Stage 1: weight lookup and product
    assign lw_qf  = {{(PW-COEF_WIDTH){src_t_data[(l+1)*COEF_WIDTH-1]}},
                     src_t_data[l*COEF_WIDTH +: COEF_WIDTH]};
    assign lw_k   = 6'(int'(cnt_q) * MULTIPLE + l);
    assign lw_w   = wtab_q[w_intra][lw_k];
    assign lw_dc  = w_intra && (lw_k == 6'd0);
    assign lw_wx  = PW'({1'b0, lw_w});
    assign lw_qsx = PW'({1'b0, w_qs});

    always_comb begin
      lw_m = lw_qf <<< 1;
      // Non-intra adds sign(QF) so that the reconstruction is biased
      // away from zero before the final truncating divide.
      if (!w_intra) begin
        if (lw_qf[PW-1]) begin
          lw_m = lw_m - PW'(1);
        end else if (|lw_qf) begin
          lw_m = lw_m + PW'(1);
        end
      end
      if (lw_dc) begin
        // 8 >> precision expressed as a left shift of QF
        lw_prod = lw_qf <<< (2'd3 - w_prec);
      end else begin
        lw_prod = lw_m * lw_wx * lw_qsx;
      end
    end

    assign w_prod[l] = lw_prod;
    assign w_dc[l]   = lw_dc;

    // Stage 2: divide by 32 toward zero, then saturate
    always_comb begin
      if (s1_dc_q[l]) begin
        lw_div = s1_prod_q[l];
      end else if (s1_prod_q[l][PW-1]) begin
        lw_div = (s1_prod_q[l] + PW'(31)) >>> 5;
      end else begin
        lw_div = s1_prod_q[l] >>> 5;
      end

      if (lw_div > C_SAT_MAX) begin
        lw_res = C_SAT_MAX[COEF_WIDTH-1:0];
      end else if (lw_div < C_SAT_MIN) begin
        lw_res = C_SAT_MIN[COEF_WIDTH-1:0];
      end else begin
        lw_res = lw_div[COEF_WIDTH-1:0];
      end
    end

    assign w_res[l] = lw_res;
  end

  logic [DATA_WIDTH-1:0] w_res_flat;

  always_comb begin
    w_res_flat = '0;
    for (int l = 0; l < MULTIPLE; l++) begin
      w_res_flat[l*COEF_WIDTH +: COEF_WIDTH] = w_res[l];
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic [DEST_WIDTH-1:0] s1_dest_q;
  logic [USER_WIDTH-1:0] s1_user_q;
  logic                  dst_last_q;
  logic [DEST_WIDTH-1:0] dst_dest_q;
  logic [USER_WIDTH-1:0] dst_user_q;
  logic [DATA_WIDTH-1:0] dst_data_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_dest_q   <= '0;
      s1_user_q   <= '0;
      dst_valid_q <= 1'b0;
      dst_last_q  <= 1'b0;
      dst_dest_q  <= '0;
      dst_user_q  <= '0;
      dst_data_q  <= '0;
      for (int l = 0; l < MULTIPLE; l++) begin
        s1_prod_q[l] <= '0;
        s1_dc_q[l]   <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        s1_valid_q  <= src_t_valid;
        s1_last_q   <= src_t_valid && src_t_last;
        s1_dest_q   <= src_t_dest;
        s1_user_q   <= src_t_user[USER_WIDTH+8:9];
        for (int l = 0; l < MULTIPLE; l++) begin
          s1_prod_q[l] <= w_prod[l];
          s1_dc_q[l]   <= w_dc[l];
        end
        dst_valid_q <= s1_valid_q;
        dst_last_q  <= s1_last_q;
        dst_dest_q  <= s1_dest_q;
        dst_user_q  <= s1_user_q;
        dst_data_q  <= w_res_flat;
      end
    end
  end

  assign dst_t_valid = dst_valid_q;
  assign dst_t_last  = dst_last_q;
  assign dst_t_dest  = dst_dest_q;
  assign dst_t_user  = dst_user_q;
  assign dst_t_data  = dst_data_q;
  assign dst_t_strb  = '1;
  assign dst_t_keep  = '1;
  assign dst_t_id    = '0;

  // Partial beats (null bytes) are not supported by this stage.
  a_full_bytes: assert property (@(posedge aclk) disable iff (!aresetn)
      accept |-> (&src_t_keep && &src_t_strb))
    else $error("dequant: accepted beat with null bytes is not supported");

endmodule
`default_nettype wire

// File: doc/dequant.md
Name: dequant

Overview:
- Inverse-quantisation stage of the video decode coefficient pipeline.
- Consumes raster-ordered quantised coefficients, MULTIPLE per beat, 64 per block.
- Applies the per-position weight matrix, quantiser scale and intra-DC multiplier.
- Saturates each result to the signed COEF_WIDTH range and feeds the saturate/mismatch stage directly downstream.

Parameters:
- COEF_WIDTH, 16, width of one coefficient lane.
- DATA_WIDTH, 64, stream data width; MULTIPLE = DATA_WIDTH/COEF_WIDTH lanes per beat.
- USER_WIDTH, 1, pass-through user bits delivered on dst.t_user.
- DEST_WIDTH, 1, t_dest width, passed through unchanged.

Ports:
- aclk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- src  nasti_stream_channel.slave  -  quantised coefficients; t_user width USER_WIDTH+9
- dst  nasti_stream_channel.master  -  dequantised coefficients; t_user width USER_WIDTH
- wm_we  input  1  weight matrix write strobe
- wm_sel  input  1  0 = non-intra table, 1 = intra table
- wm_addr  input  6  raster coefficient index
- wm_data  input  8  weight value

Behaviour:
- Clock and reset: one clock, aclk; reset aresetn is asynchronous, active-low.
- Reset values: dst.t_valid=0, dst.t_last=0, stage-1 valid=0, coefficient beat counter=0; every entry of both weight tables = 16.
- Tied outputs: dst.t_strb='1, dst.t_keep='1, dst.t_id='0.
- src.t_user layout:
  - [4:0] quantiser_scale_code
  - [5] intra
  - [7:6] intra_dc_precision
  - [8] q_scale_type
  - [USER_WIDTH+8:9] pass-through, delivered on dst.t_user
- Sideband timing: control fields are sampled per beat and must be constant within a block. dst.t_dest = src.t_dest, dst.t_last = src.t_last, both delayed with the data.
- Pipeline: two register stages.
  - Stage 1: weight lookup and product.
  - Stage 2 (dst regs): divide and saturate.
- Advance enable: en = !dst.t_valid || dst.t_ready. src.t_ready = en.
- Latency: a beat accepted at cycle N is presented on dst at cycle N+2 if never stalled.
- Stalls: no bubble insertion, no beat drop or duplication.
- Null bytes: an accepted beat without &t_keep and &t_strb raises $error (not supported).
- Coefficient index: k = cnt*MULTIPLE + lane, with cnt in 0..64/MULTIPLE-1. cnt increments per accepted beat and returns to 0 on an accepted t_last beat, or after the 16th beat when t_last is absent (wrap).
- Arithmetic: QF is lane data sign-extended; qs = 2*quantiser_scale_code (linear); W = table[wm_sel=intra][k].
  - Intra, k=0: F = QF * (8 >> intra_dc_precision).
  - Intra, k>0: F = (2*QF*W*qs) / 32.
  - Non-intra: F = ((2*QF + sign(QF))*W*qs) / 32, where sign(0)=0.
  - Division truncates toward zero.
  - Intermediates are at least COEF_WIDTH+17 bits signed.
  - Final result is saturated to [-2^(COEF_WIDTH-1), 2^(COEF_WIDTH-1)-1].
- Weight writes: a write on wm_we updates the table at the clock edge and affects beats sampled from the next cycle onward. Writes are legal only between blocks; mid-block results are undefined but the handshake stays intact.
- Simultaneous events: accept and output in the same cycle is supported at full throughput. Reset mid-block discards all in-flight beats and restores the tables to 16.

Optional Feature:
- Macro: DEQUANT_NONLINEAR_QSCALE_EN.
- Defined: when q_scale_type=1, qs comes from the nonlinear table indexed by code 0..31: 0,1,2,3,4,5,6,7,8,10,12,14,16,18,20,22,24,28,32,36,40,44,48,52,56,64,72,80,88,96,104,112. When q_scale_type=0, qs = 2*code.
- Undefined: bit [8] is ignored and qs = 2*code always.

Test Plan:
- Non-intra, W=16, code=2 (qs=4):
  - QF=+3 -> 14.
  - QF=-3 -> -14.
  - QF=0 -> 0.
  - With W[5]=17, code=1, QF=-1 at k=5 -> -3 (toward zero, not -4).
- Intra, precision 0, code=2, W=16:
  - k=0 QF=100 -> 800.
  - k=1 QF=10 -> 40.
  - Precision 3, k=0 QF=100 -> 100.
- Saturation, non-intra, W=255, code=31:
  - QF=2047 -> 32767.
  - QF=-2048 -> -32768.
- Backpressure: 16-beat block with dst.t_ready low for cycles 3-7.
  - src.t_ready falls once both stages are full.
  - All 16 beats arrive in order, exactly once; t_last only on beat 16.
- Early t_last on beat 4, then a new intra block: first lane of the next block is treated as DC (k=0 -> QF*8). No t_last -> cnt wraps after beat 16.
- Write intra W[1]=32, then intra code=2, k=1 QF=10 -> 80.
- With DEQUANT_NONLINEAR_QSCALE_EN, q_scale_type=1, code=31, non-intra W=16 QF=1 -> (3*16*112)/32 = 168. Same stimulus without the macro -> (3*16*62)/32 = 93.
